// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch unit
// (master) and instruction memory (slave).
interface instr_fetch_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [31:0]     mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns pc / old_pc / instr, runs the instruction
// memory handshake and exposes decoded opcode fields to the controller.
// Misaligned fetches and response timeouts park the block in a terminal
// error state until reset.
module instr_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fetch_start,
   input  logic                pc_write,
   input  logic [XLEN-1:0]     pc_next,
   instr_fetch_unit_if.master  mem,
   output logic [XLEN-1:0]     pc,
   output logic [XLEN-1:0]     old_pc,
   output logic [31:0]         instr,
   output logic [6:0]          opc,
   output logic [2:0]          f3,
   output logic [6:0]          f7,
   output logic                instr_valid,
   output logic                busy,
   output logic                fetch_err
);

   // A zero TIMEOUT still gets a 1-bit counter so the logic stays well formed.
   localparam int unsigned    CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
   localparam bit             TMO_EN  = (TIMEOUT != 0);
   localparam logic [31:0]    NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] old_pc_q, old_pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [31:0]     instr_q, instr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            mem_req_q, mem_req_d;
   logic            instr_valid_q, instr_valid_d;
   logic            busy_q, busy_d;
   logic            fetch_err_q, fetch_err_d;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_write ? pc_next : pc_q;
      old_pc_d      = old_pc_q;
      addr_d        = addr_q;
      instr_d       = instr_q;
      cnt_d         = cnt_q;
      instr_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            // The fetch latches the pre-update pc even if pc_write is also high.
            if (fetch_start) begin
               if (pc_q[1:0] != 2'b00) begin
                  state_d = S_ERR;
               end else begin
                  addr_d  = pc_q;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            // An rvalid coincident with the grant is deliberately not consumed.
            if (mem.mem_gnt) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem.mem_rvalid) begin
               instr_d       = mem.mem_rdata;
               old_pc_d      = addr_q;
               instr_valid_d = 1'b1;
               state_d       = S_IDLE;
            end else if (TMO_EN && (cnt_q == TMO_CNT)) begin
               state_d = S_ERR;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      mem_req_d   = (state_d == S_REQ);
      busy_d      = (state_d == S_REQ) || (state_d == S_WAIT);
      fetch_err_d = (state_d == S_ERR);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         old_pc_q      <= RESET_PC;
         addr_q        <= RESET_PC;
         instr_q       <= NOP;
         cnt_q         <= '0;
         mem_req_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         fetch_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         old_pc_q      <= old_pc_d;
         addr_q        <= addr_d;
         instr_q       <= instr_d;
         cnt_q         <= cnt_d;
         mem_req_q     <= mem_req_d;
         instr_valid_q <= instr_valid_d;
         busy_q        <= busy_d;
         fetch_err_q   <= fetch_err_d;
      end
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = addr_q;

   assign pc          = pc_q;
   assign old_pc      = old_pc_q;
   assign instr       = instr_q;
   assign opc         = instr_q[6:0];
   assign f3          = instr_q[14:12];
   assign f7          = instr_q[31:25];
   assign instr_valid = instr_valid_q;
   assign busy        = busy_q;
   assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a scoreboard of expected
// fetch results is filled when a fetch is launched and drained when
// instr_valid appears; handshake timing is checked cycle by cycle.
module tb_instr_fetch_unit;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            fetch_start = 1'b0;
   logic            pc_write = 1'b0;
   logic [XLEN-1:0] pc_next = '0;
   logic [XLEN-1:0] pc, old_pc;
   logic [31:0]     instr;
   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic            instr_valid, busy, fetch_err;

   instr_fetch_unit_if #(.XLEN(XLEN)) mem_if ();

   instr_fetch_unit #(
      .XLEN     (XLEN),
      .RESET_PC (32'h0000_0000),
      .TIMEOUT  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .pc_write    (pc_write),
      .pc_next     (pc_next),
      .mem         (mem_if),
      .pc          (pc),
      .old_pc      (old_pc),
      .instr       (instr),
      .opc         (opc),
      .f3          (f3),
      .f7          (f7),
      .instr_valid (instr_valid),
      .busy        (busy),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] pc_model = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      fetch_start = 1'b0;
      pc_write    = 1'b0;
      mem_if.mem_gnt    = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      @(negedge clk);
      rst      = 1'b1;
      pc_model = 32'h0;
      exp_q.delete();
   endtask

   task automatic check_reset_state();
      check("rst_pc",       pc,              32'h0);
      check("rst_old_pc",   old_pc,          32'h0);
      check("rst_instr",    instr,           32'h0000_0013);
      check("rst_mem_req",  mem_if.mem_req,  0);
      check("rst_mem_addr", mem_if.mem_addr, 32'h0);
      check("rst_valid",    instr_valid,     0);
      check("rst_busy",     busy,            0);
      check("rst_err",      fetch_err,       0);
   endtask

   // One complete fetch; called at a negedge with the DUT in IDLE.
   task automatic run_fetch(input logic [31:0] data, input int gnt_dly, input bit early_rv,
                            input bit do_pcw, input logic [31:0] pcw_val);
      exp_t        e;
      logic [31:0] a;
      int          k;
      a      = pc_model;
      e.addr = a;
      e.data = data;
      exp_q.push_back(e);
      fetch_start = 1'b1;
      pc_write    = do_pcw;
      pc_next     = pcw_val;
      @(negedge clk);
      fetch_start = 1'b0;
      pc_write    = 1'b0;
      if (do_pcw) pc_model = pcw_val;
      check("pc_after_start", pc, pc_model);
      for (int i = 0; i <= gnt_dly; i++) begin
         check("req_high", mem_if.mem_req,  1);
         check("req_addr", mem_if.mem_addr, a);
         check("req_busy", busy,            1);
         mem_if.mem_gnt = (i == gnt_dly);
         if (early_rv && (i == gnt_dly)) begin
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata  = 32'hDEAD_BEEF;
         end
         @(negedge clk);
      end
      mem_if.mem_gnt    = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      check("wait_req_low",  mem_if.mem_req, 0);
      check("wait_busy",     busy,           1);
      check("wait_no_valid", instr_valid,    0);
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = data;
      @(negedge clk);
      mem_if.mem_rvalid = 1'b0;
      k = 0;
      while (!instr_valid && k < 4) begin
         @(negedge clk);
         k++;
      end
      check("valid_latency", k, 0);
      check("idle_busy", busy, 0);
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_instr",  instr,  e.data);
         check("sb_old_pc", old_pc, e.addr);
         check("sb_opc",    opc,    32'(e.data[6:0]));
         check("sb_f3",     f3,     32'(e.data[14:12]));
         check("sb_f7",     f7,     32'(e.data[31:25]));
         $display("fetch addr=%h instr=%h old_pc=%h pc=%h", e.addr, instr, old_pc, pc);
      end
      @(negedge clk);
      check("valid_once", instr_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_if.mem_gnt    = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = '0;
      @(negedge clk);
      do_reset();
      check_reset_state();

      // Zero-wait fetch of an R-type word.
      run_fetch(32'h0000_0033, 0, 1'b0, 1'b0, 32'h0);
      check("t1_opc", opc, 32'h33);
      check("t1_f3",  f3,  32'h0);
      check("t1_f7",  f7,  32'h0);

      // Reset pc is 0 again; fetch with simultaneous pc_write and slow grant.
      do_reset();
      run_fetch(32'h0000_0013, 2, 1'b0, 1'b1, 32'h0000_0004);
      check("t2_pc",     pc,     32'h4);
      check("t2_old_pc", old_pc, 32'h0);

      // rvalid with grant is not consumed; the WAIT-cycle response is.
      run_fetch(32'h0040_0093, 0, 1'b1, 1'b0, 32'h0);
      check("t6_opc",   opc,    32'h13);
      check("t6_instr", instr,  32'h0040_0093);
      check("t6_oldpc", old_pc, 32'h4);

      // Response timeout: five WAIT cycles then a permanent error.
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("tmo_req", mem_if.mem_req, 1);
      mem_if.mem_gnt = 1'b1;
      @(negedge clk);
      mem_if.mem_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("tmo_busy",    busy,      1);
         check("tmo_err_low", fetch_err, 0);
         @(negedge clk);
      end
      check("tmo_err",   fetch_err,      1);
      check("tmo_idle",  busy,           0);
      check("tmo_req0",  mem_if.mem_req, 0);
      check("tmo_instr", instr,          32'h0040_0093);
      $display("timeout fetch_err=%0d busy=%0d", fetch_err, busy);

      // Reset in WAIT, then a late response that must be ignored.
      do_reset();
      check_reset_state();
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      mem_if.mem_gnt = 1'b1;
      @(negedge clk);
      mem_if.mem_gnt = 1'b0;
      check("mid_wait_busy", busy, 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("mid_rst_req",  mem_if.mem_req, 0);
      check("mid_rst_busy", busy,           0);
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_if.mem_rvalid = 1'b0;
      check("late_rv_instr", instr,       32'h0000_0013);
      check("late_rv_valid", instr_valid, 0);
      @(negedge clk);
      check("late_rv_valid2", instr_valid, 0);
      $display("reset-mid-fetch instr=%h", instr);

      // Misaligned pc: immediate sticky error, no memory request.
      pc_write = 1'b1;
      pc_next  = 32'h0000_0102;
      @(negedge clk);
      pc_write = 1'b0;
      check("mis_pc", pc, 32'h0000_0102);
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("mis_err",  fetch_err,      1);
      check("mis_req",  mem_if.mem_req, 0);
      check("mis_busy", busy,           0);
      for (int i = 0; i < 3; i++) begin
         fetch_start = (i == 1);
         @(negedge clk);
         check("mis_err_sticky", fetch_err,      1);
         check("mis_req_ign",    mem_if.mem_req, 0);
      end
      fetch_start = 1'b0;
      pc_write    = 1'b1;
      pc_next     = 32'h0000_0200;
      @(negedge clk);
      pc_write = 1'b0;
      check("err_pc_write", pc, 32'h0000_0200);
      check("err_still",    fetch_err, 1);
      $display("misaligned fetch_err=%0d pc=%h", fetch_err, pc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
